// File: rtl/psg_pkg.sv
// Shared constants for the PSG bus controller: bus modes, register indices,
// phase states and per-register width masks.
package psg_pkg;

    localparam logic [1:0] BUS_INACTIVE = 2'b00;
    localparam logic [1:0] BUS_READ     = 2'b01;
    localparam logic [1:0] BUS_WRITE    = 2'b10;
    localparam logic [1:0] BUS_LATCH    = 2'b11;

    localparam logic [3:0] REG_TONE_A_FINE   = 4'd0;
    localparam logic [3:0] REG_TONE_A_COARSE = 4'd1;
    localparam logic [3:0] REG_TONE_B_FINE   = 4'd2;
    localparam logic [3:0] REG_TONE_B_COARSE = 4'd3;
    localparam logic [3:0] REG_TONE_C_FINE   = 4'd4;
    localparam logic [3:0] REG_TONE_C_COARSE = 4'd5;
    localparam logic [3:0] REG_NOISE_PERIOD  = 4'd6;
    localparam logic [3:0] REG_MIXER         = 4'd7;
    localparam logic [3:0] REG_AMP_A         = 4'd8;
    localparam logic [3:0] REG_AMP_B         = 4'd9;
    localparam logic [3:0] REG_AMP_C         = 4'd10;
    localparam logic [3:0] REG_ENV_FINE      = 4'd11;
    localparam logic [3:0] REG_ENV_COARSE    = 4'd12;
    localparam logic [3:0] REG_ENV_SHAPE     = 4'd13;
    localparam logic [3:0] REG_IO_A          = 4'd14;
    localparam logic [3:0] REG_IO_B          = 4'd15;

    // Encoding matches the bus mode so the state is simply last cycle's mode.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_LATCH = 2'b11
    } bus_state_t;

    function automatic logic [7:0] reg_mask(input logic [3:0] idx);
        case (idx)
            REG_TONE_A_COARSE, REG_TONE_B_COARSE,
            REG_TONE_C_COARSE, REG_ENV_SHAPE:       reg_mask = 8'h0F;
            REG_NOISE_PERIOD, REG_AMP_A,
            REG_AMP_B, REG_AMP_C:                   reg_mask = 8'h1F;
            default:                                reg_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/psg_bus_fsm.sv
// Bus phase tracker: the state is the previous cycle's mode, and a phase
// strobes only on the cycle it is entered.
module psg_bus_fsm
    import psg_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       i_mode,
    output bus_state_t       o_state,
    output logic             o_latch_stb,
    output logic             o_write_stb,
    output logic             o_read_act
);

    bus_state_t r_state;
    logic       w_entry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= bus_state_t'(i_mode);
        end
    end

    assign w_entry     = (i_mode != 2'(r_state));
    assign o_state     = r_state;
    assign o_latch_stb = w_entry && (i_mode == BUS_LATCH);
    assign o_write_stb = w_entry && (i_mode == BUS_WRITE);
    // Readback is a level: the output registers resample on every READ cycle.
    assign o_read_act  = (i_mode == BUS_READ);

endmodule

// File: rtl/psg_bus_ctrl.sv
// PSG bus-side register file: address latch, R0-R15 with width masks, sound
// block configuration outputs. Optional readback path under PSG_READBACK_EN.
module psg_bus_ctrl
    import psg_pkg::*;
#(
    parameter logic [3:0] ADDR_HI = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bdir,
    input  logic        bc1,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [11:0] tone_period_a,
    output logic [11:0] tone_period_b,
    output logic [11:0] tone_period_c,
    output logic [4:0]  noise_period,
    output logic [2:0]  tone_disable,
    output logic [2:0]  noise_disable,
    output logic [4:0]  amp_a,
    output logic [4:0]  amp_b,
    output logic [4:0]  amp_c,
    output logic [15:0] env_period,
    output logic [3:0]  env_shape,
    output logic        env_restart
);

    logic [7:0] r_regs [16];
    logic [3:0] r_addr;
    logic       r_sel;
    logic       r_env_restart;
    logic [1:0] w_mode;
    bus_state_t w_state;
    logic       w_latch_stb;
    logic       w_write_stb;
    logic       w_read_act;

`ifdef PSG_READBACK_EN
    assign w_mode = {bdir, bc1};
`else
    assign w_mode = ({bdir, bc1} == BUS_READ) ? BUS_INACTIVE : {bdir, bc1};
`endif

    psg_bus_fsm u_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_mode      (w_mode),
        .o_state     (w_state),
        .o_latch_stb (w_latch_stb),
        .o_write_stb (w_write_stb),
        .o_read_act  (w_read_act)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_addr        <= 4'h0;
            r_sel         <= 1'b1;
            r_env_restart <= 1'b0;
        end else begin
            r_env_restart <= 1'b0;
            if (w_latch_stb) begin
                r_addr <= data_in[3:0];
                r_sel  <= (data_in[7:4] == ADDR_HI);
            end
            if (w_write_stb && r_sel) begin
                r_regs[r_addr] <= data_in & reg_mask(r_addr);
                r_env_restart  <= (r_addr == REG_ENV_SHAPE);
            end
        end
    end

`ifdef PSG_READBACK_EN
    logic [7:0] r_dout;
    logic       r_oe;
    logic [1:0] w_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= 8'h00;
            r_oe   <= 1'b0;
        end else if (w_read_act && r_sel) begin
            r_dout <= r_regs[r_addr];
            r_oe   <= 1'b1;
        end else begin
            r_dout <= 8'h00;
            r_oe   <= 1'b0;
        end
    end

    assign data_out = r_dout;
    assign data_oe  = r_oe;
    assign w_unused = w_state;
`else
    logic [2:0] w_unused;

    assign data_out = 8'h00;
    assign data_oe  = 1'b0;
    assign w_unused = {w_state, w_read_act};
`endif

    assign tone_period_a = {r_regs[REG_TONE_A_COARSE][3:0], r_regs[REG_TONE_A_FINE]};
    assign tone_period_b = {r_regs[REG_TONE_B_COARSE][3:0], r_regs[REG_TONE_B_FINE]};
    assign tone_period_c = {r_regs[REG_TONE_C_COARSE][3:0], r_regs[REG_TONE_C_FINE]};
    assign noise_period  = r_regs[REG_NOISE_PERIOD][4:0];
    assign tone_disable  = r_regs[REG_MIXER][2:0];
    assign noise_disable = r_regs[REG_MIXER][5:3];
    assign amp_a         = r_regs[REG_AMP_A][4:0];
    assign amp_b         = r_regs[REG_AMP_B][4:0];
    assign amp_c         = r_regs[REG_AMP_C][4:0];
    assign env_period    = {r_regs[REG_ENV_COARSE], r_regs[REG_ENV_FINE]};
    assign env_shape     = r_regs[REG_ENV_SHAPE][3:0];
    assign env_restart   = r_env_restart;

endmodule

// File: tb/tb_psg_bus_ctrl.sv
// Scoreboard bench for psg_bus_ctrl: directed test-plan sequences plus random
// bus traffic, each cycle compared against a register-file reference model.
module tb_psg_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bdir = 1'b0;
    logic        bc1 = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [11:0] tone_period_a, tone_period_b, tone_period_c;
    logic [4:0]  noise_period;
    logic [2:0]  tone_disable, noise_disable;
    logic [4:0]  amp_a, amp_b, amp_c;
    logic [15:0] env_period;
    logic [3:0]  env_shape;
    logic        env_restart;

    psg_bus_ctrl #(.ADDR_HI(4'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .bdir          (bdir),
        .bc1           (bc1),
        .data_in       (data_in),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .tone_period_a (tone_period_a),
        .tone_period_b (tone_period_b),
        .tone_period_c (tone_period_c),
        .noise_period  (noise_period),
        .tone_disable  (tone_disable),
        .noise_disable (noise_disable),
        .amp_a         (amp_a),
        .amp_b         (amp_b),
        .amp_c         (amp_c),
        .env_period    (env_period),
        .env_shape     (env_shape),
        .env_restart   (env_restart)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] tpa;
        logic [11:0] tpb;
        logic [11:0] tpc;
        logic [4:0]  np;
        logic [2:0]  td;
        logic [2:0]  nd;
        logic [4:0]  aa;
        logic [4:0]  ab;
        logic [4:0]  ac;
        logic [15:0] ep;
        logic [3:0]  es;
        logic        er;
        logic [7:0]  dout;
        logic        doe;
    } outs_t;

    outs_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    // Reference model: a plain byte array plus the latched address/select.
    logic [7:0] m_regs [16];
    logic [3:0] m_addr;
    logic       m_sel;
    int         m_prev;
    logic       m_er;
    logic       m_oe;
    logic [7:0] m_dout;

    function automatic logic [7:0] tb_mask(input int idx);
        if (idx == 1 || idx == 3 || idx == 5 || idx == 13) return 8'h0F;
        if (idx == 6 || idx == 8 || idx == 9 || idx == 10) return 8'h1F;
        return 8'hFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_addr = 4'h0;
        m_sel  = 1'b1;
        m_prev = 0;
        m_er   = 1'b0;
        m_oe   = 1'b0;
        m_dout = 8'h00;
    endtask

    task automatic model_edge(input int mode, input logic [7:0] d);
        int  eff;
        bit  entry;
        eff = mode;
`ifndef PSG_READBACK_EN
        if (eff == 1) eff = 0;
`endif
        entry  = (eff != m_prev);
        m_er   = 1'b0;
        m_oe   = 1'b0;
        m_dout = 8'h00;
        if (eff == 1 && m_sel) begin
            m_oe   = 1'b1;
            m_dout = m_regs[m_addr];
        end
        if (entry && eff == 3) begin
            m_addr = d[3:0];
            m_sel  = (d[7:4] == 4'h0);
        end
        if (entry && eff == 2 && m_sel) begin
            m_regs[m_addr] = d & tb_mask(int'(m_addr));
            m_er = (m_addr == 4'd13);
        end
        m_prev = eff;
    endtask

    function automatic outs_t model_outs();
        outs_t o;
        o.tpa  = {m_regs[1][3:0], m_regs[0]};
        o.tpb  = {m_regs[3][3:0], m_regs[2]};
        o.tpc  = {m_regs[5][3:0], m_regs[4]};
        o.np   = m_regs[6][4:0];
        o.td   = m_regs[7][2:0];
        o.nd   = m_regs[7][5:3];
        o.aa   = m_regs[8][4:0];
        o.ab   = m_regs[9][4:0];
        o.ac   = m_regs[10][4:0];
        o.ep   = {m_regs[12], m_regs[11]};
        o.es   = m_regs[13][3:0];
        o.er   = m_er;
        o.dout = m_dout;
        o.doe  = m_oe;
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.tpa  = tone_period_a;
        o.tpb  = tone_period_b;
        o.tpc  = tone_period_c;
        o.np   = noise_period;
        o.td   = tone_disable;
        o.nd   = noise_disable;
        o.aa   = amp_a;
        o.ab   = amp_b;
        o.ac   = amp_c;
        o.ep   = env_period;
        o.es   = env_shape;
        o.er   = env_restart;
        o.dout = data_out;
        o.doe  = data_oe;
        return o;
    endfunction

    // Monitor: every expected snapshot is compared on the falling edge.
    initial begin
        outs_t e;
        outs_t g;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_outs();
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, g, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input int mode, input logic [7:0] d);
        bdir    = mode[1];
        bc1     = mode[0];
        data_in = d;
        @(posedge clk);
        model_edge(mode, d);
        exp_q.push_back(model_outs());
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rd;
        model_reset();
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        step(0, 8'h00);
        chk("rst_tone_a", 32'(tone_period_a), 32'h0);
        chk("rst_env", 32'(env_period), 32'h0);
        chk("rst_oe", 32'(data_oe), 32'h0);

        // Noise period write with masking
        step(3, 8'h06);
        step(2, 8'hFF);
        chk("noise_mask", 32'(noise_period), 32'h1F);
`ifdef PSG_READBACK_EN
        step(1, 8'h00);
        chk("rd_oe", 32'(data_oe), 32'h1);
        chk("rd_data", 32'(data_out), 32'h1F);
`endif
        step(0, 8'h00);

        // Deselected chip ignores the write
        step(3, 8'h1D);
        step(2, 8'h0A);
        chk("desel_shape", 32'(env_shape), 32'h0);
        chk("desel_restart", 32'(env_restart), 32'h0);
`ifdef PSG_READBACK_EN
        step(1, 8'h00);
        chk("desel_oe", 32'(data_oe), 32'h0);
`endif
        step(0, 8'h00);

        // Held WRITE acts once
        step(3, 8'h00);
        for (int i = 1; i <= 5; i++) step(2, 8'(8'h11 * i));
        chk("hold_once", 32'(tone_period_a), 32'h011);
        step(0, 8'h00);

        // Envelope restart on every R13 write
        step(3, 8'h0D);
        step(2, 8'h0E);
        chk("restart1", 32'(env_restart), 32'h1);
        step(0, 8'h00);
        chk("restart1_end", 32'(env_restart), 32'h0);
        step(2, 8'h0E);
        chk("restart2", 32'(env_restart), 32'h1);
        chk("shape", 32'(env_shape), 32'hE);
        step(0, 8'h00);
        chk("restart2_end", 32'(env_restart), 32'h0);

        // Reset during a WRITE to R12
        step(3, 8'h07);
        step(2, 8'h38);
        step(3, 8'h00);
        step(2, 8'h55);
        chk("mixer_nd", 32'(noise_disable), 32'h7);
        chk("tone_a_55", 32'(tone_period_a), 32'h055);
        step(3, 8'h0C);
        bdir = 1'b1; bc1 = 1'b0; data_in = 8'h77;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        exp_q.push_back(model_outs());
        @(negedge clk); #1;
        bdir = 1'b0;
        @(posedge clk);
        exp_q.push_back(model_outs());
        @(negedge clk); #1;
        reset = 1'b0;
        step(0, 8'h00);
        chk("rst_mid_env", 32'(env_period), 32'h0);
        chk("rst_mid_nd", 32'(noise_disable), 32'h0);
        chk("rst_mid_tone", 32'(tone_period_a), 32'h0);

`ifndef PSG_READBACK_EN
        for (int i = 0; i < 3; i++) begin
            step(1, 8'hA5);
            chk("noread_oe", 32'(data_oe), 32'h0);
            chk("noread_data", 32'(data_out), 32'h0);
        end
        step(0, 8'h00);
`endif

        // Random bus traffic, mostly selecting the chip
        for (int i = 0; i < 600; i++) begin
            rd = 8'($urandom);
            if ($urandom_range(0, 3) != 0) rd[7:4] = 4'h0;
            step(int'($urandom_range(0, 3)), rd);
        end
        step(0, 8'h00);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
